// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder with a bank of NUM_REGS 32-bit read/write registers.
// Build option: define AXI4_LITE_SLAVE_SLVERR_EN to answer out-of-window accesses with SLVERR.
//
// state        | meaning
// W_IDLE       | awready=wready=1, waiting for AW and/or W
// W_WAIT_DATA  | address latched, waiting for W
// W_WAIT_ADDR  | data/strobes latched, waiting for AW
// W_RESP       | bvalid held until bready
// R_IDLE       | arready=1, waiting for AR
// R_DATA       | rvalid held until rready
module axi4_lite_slave_regs #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_2000,
  parameter int                    NUM_REGS   = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int IDXW = $clog2(NUM_REGS);

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_WAIT_DATA = 2'd1;
  localparam logic [1:0] W_WAIT_ADDR = 2'd2;
  localparam logic [1:0] W_RESP      = 2'd3;
  localparam logic [0:0] R_IDLE      = 1'b0;
  localparam logic [0:0] R_DATA      = 1'b1;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_SLAVE_SLVERR_EN
  localparam logic [1:0] RESP_MISS = 2'b10;
`else
  localparam logic [1:0] RESP_MISS = 2'b00;
`endif

  logic [1:0]            r_wstate;
  logic [0:0]            r_rstate;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_regs [NUM_REGS];

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [31:0]           w_wr_data;
  logic [3:0]            w_wr_strb;
  logic                  w_wr_hit;
  logic [IDXW-1:0]       w_wr_idx;
  logic                  w_rd_hit;
  logic [IDXW-1:0]       w_rd_idx;
  logic                  w_unused_ok;

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;

  // The commit source depends on which half of the write was latched earlier.
  assign w_wr_en   = ((r_wstate == W_IDLE) && w_aw_hs && w_w_hs) ||
                     ((r_wstate == W_WAIT_DATA) && w_w_hs) ||
                     ((r_wstate == W_WAIT_ADDR) && w_aw_hs);
  assign w_wr_addr = (r_wstate == W_WAIT_DATA) ? r_awaddr : awaddr;
  assign w_wr_data = (r_wstate == W_WAIT_ADDR) ? r_wdata : wdata;
  assign w_wr_strb = (r_wstate == W_WAIT_ADDR) ? r_wstrb : wstrb;

  // Window is aligned to its size, so a tag compare is the full range check.
  assign w_wr_hit = (w_wr_addr[ADDR_WIDTH-1:IDXW+2] == BASE_ADDR[ADDR_WIDTH-1:IDXW+2]);
  assign w_wr_idx = w_wr_addr[IDXW+1:2];
  assign w_rd_hit = (araddr[ADDR_WIDTH-1:IDXW+2] == BASE_ADDR[ADDR_WIDTH-1:IDXW+2]);
  assign w_rd_idx = araddr[IDXW+1:2];

  assign w_unused_ok = &{1'b0, awprot, arprot, w_wr_addr[1:0], araddr[1:0]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs && w_w_hs) begin
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= w_wr_hit ? RESP_OKAY : RESP_MISS;
            r_wstate <= W_RESP;
          end else if (w_aw_hs) begin
            r_awaddr <= awaddr;
            awready  <= 1'b0;
            r_wstate <= W_WAIT_DATA;
          end else if (w_w_hs) begin
            r_wdata  <= wdata;
            r_wstrb  <= wstrb;
            wready   <= 1'b0;
            r_wstate <= W_WAIT_ADDR;
          end else begin
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        W_WAIT_DATA: begin
          if (w_w_hs) begin
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= w_wr_hit ? RESP_OKAY : RESP_MISS;
            r_wstate <= W_RESP;
          end
        end
        W_WAIT_ADDR: begin
          if (w_aw_hs) begin
            awready  <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= w_wr_hit ? RESP_OKAY : RESP_MISS;
            r_wstate <= W_RESP;
          end
        end
        default: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            r_wstate <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en && w_wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_strb[b]) r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  // Same-edge read of a register being written returns the pre-write value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arvalid && arready) begin
            rdata    <= w_rd_hit ? r_regs[w_rd_idx] : 32'h0;
            rresp    <= w_rd_hit ? RESP_OKAY : RESP_MISS;
            rvalid   <= 1'b1;
            arready  <= 1'b0;
            r_rstate <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        default: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            r_rstate <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule
